// File: rtl/ccx_emem_responder.sv
// Target end of the core complex external memory bus: serves emem_* requests
// from a local byte-strobed 64-bit memory after a fixed, programmable wait.
module ccx_emem_responder #(
  parameter int              AW          = 39,
  parameter int              DW          = 64,
  parameter logic [AW-1:0]   MEM_BASE    = 39'h10000000,
  parameter int              MEM_DEPTH   = 1024,
  parameter int              WAIT_CYCLES = 2,
  parameter string           MEMH        = ""
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              emem_req,
  input  logic [AW-1:0]     emem_addr,
  input  logic              emem_wen,
  input  logic [DW/8-1:0]   emem_strb,
  input  logic [DW-1:0]     emem_wdata,
  output logic              emem_gnt,
  output logic              emem_err,
  output logic [DW-1:0]     emem_rdata
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(MEM_DEPTH);
  // One extra bit so the window end cannot wrap when compared against addresses.
  localparam logic [AW:0] MEM_END = {1'b0, MEM_BASE} + (AW+1)'(MEM_DEPTH) * (AW+1)'(8);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_q;
  logic            wen_q;
  logic [SW-1:0]   strb_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   mem [MEM_DEPTH];

  logic [AW-1:0]   dec_addr;
  logic            dec_wen;
  logic            in_range;
  logic [IW-1:0]   idx;
  logic            go_resp;

  // Decode the live request while capturing (needed when WAIT_CYCLES=0),
  // otherwise always the latched copy.
  always_comb begin
    dec_addr = addr_q;
    dec_wen  = wen_q;
    if (state == IDLE) begin
      dec_addr = emem_addr;
      dec_wen  = emem_wen;
    end
    in_range = ({1'b0, dec_addr} >= {1'b0, MEM_BASE}) && ({1'b0, dec_addr} < MEM_END);
    idx      = IW'((dec_addr - MEM_BASE) >> 3);
    go_resp  = ((state == IDLE) && emem_req && (WAIT_CYCLES == 0)) ||
               ((state == WAIT) && (cnt == 4'd1));
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      strb_q     <= '0;
      wdata_q    <= '0;
      emem_gnt   <= 1'b0;
      emem_err   <= 1'b0;
      emem_rdata <= '0;
    end else begin
      emem_gnt   <= 1'b0;
      emem_err   <= 1'b0;
      emem_rdata <= '0;
      if (go_resp) begin
        emem_gnt   <= 1'b1;
        emem_err   <= !in_range;
        emem_rdata <= (in_range && !dec_wen) ? mem[idx] : '0;
      end
      case (state)
        IDLE: begin
          if (emem_req) begin
            addr_q  <= emem_addr;
            wen_q   <= emem_wen;
            strb_q  <= emem_strb;
            wdata_q <= emem_wdata;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writes land on the edge that ends the gnt cycle, unless reset is taken there.
  always_ff @(posedge g_clk) begin
    if (!g_reset && (state == RESP) && wen_q && in_range) begin
      for (int i = 0; i < SW; i++) begin
        if (strb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule
